// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared FFT constants, twiddle quadrant encodings and stage FSM type
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int LOG_M_DEF = 7;
  localparam int TW_WIDTH  = 16;

  // Quadrant select; the numeric value is the twiddle-index multiplier
  localparam logic [1:0] TW_SEL_0 = 2'd0;
  localparam logic [1:0] TW_SEL_2 = 2'd1;
  localparam logic [1:0] TW_SEL_1 = 2'd2;
  localparam logic [1:0] TW_SEL_3 = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/en_delay.sv
// ============================================================================
// en_delay : reset-clearable register chain of configurable depth (0 = wire)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module en_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clock) begin
        if (reset) begin
          stage_q <= '{default: '0};
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/twiddle_seq.sv
// ============================================================================
// twiddle_seq : twiddle address sequencer for one radix-2^2 SDF FFT stage.
// Optional: TWSEQ_ZERO_ADDR_GATE_EN forces tw_addr to 0 on idle cycles.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module twiddle_seq
  import fft_pkg::*;
#(
  parameter int LOG_N = 7,
  parameter int LOG_M = LOG_M_DEF,
  parameter int TW_FF = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  output logic [LOG_M-1:0] tw_addr,
  output logic             tw_en,
  output logic             tw_bypass,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [LOG_N-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic [LOG_M-1:0] tw_addr_q, tw_addr_d;
  logic             a_en_q, a_en_d;
  logic             a_zero_q, a_zero_d;
  logic             a_last_q, a_last_d;

  logic [1:0]       tw_sel;
  logic [LOG_M-1:0] tw_num;
  logic [LOG_M-1:0] addr;
  logic             is_last;

  always_comb begin
    tw_sel  = {cnt_q[LOG_N-2], cnt_q[LOG_N-1]};
    tw_num  = LOG_M'(cnt_q[LOG_N-3:0]) << (LOG_M - LOG_N);
    is_last = (cnt_q == CNT_MAX);

    // tw_num * tw_sel as shift/add; 3*max still fits in LOG_M bits
    case (tw_sel)
      TW_SEL_0: addr = '0;
      TW_SEL_2: addr = tw_num;
      TW_SEL_1: addr = tw_num << 1;
      default:  addr = tw_num + (tw_num << 1);
    endcase

    cnt_d   = cnt_q;
    state_d = state_q;
    if (di_en) begin
      cnt_d = cnt_q + LOG_N'(1);
      case (state_q)
        IDLE:    state_d = RUN;
        default: state_d = is_last ? IDLE : RUN;
      endcase
    end

`ifdef TWSEQ_ZERO_ADDR_GATE_EN
    tw_addr_d = di_en ? addr : '0;
`else
    tw_addr_d = di_en ? addr : tw_addr_q;
`endif

    a_en_d   = di_en;
    a_zero_d = di_en & (addr == '0);
    a_last_d = di_en & is_last;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tw_addr_q <= '0;
      a_en_q    <= 1'b0;
      a_zero_q  <= 1'b0;
      a_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tw_addr_q <= tw_addr_d;
      a_en_q    <= a_en_d;
      a_zero_q  <= a_zero_d;
      a_last_q  <= a_last_d;
    end
  end

  // Qualifiers follow the table read latency so they line up with its data
  en_delay #(
    .DEPTH (TW_FF),
    .WIDTH (3)
  ) u_en_delay (
    .clock (clock),
    .reset (reset),
    .d     ({a_en_q, a_zero_q, a_last_q}),
    .q     ({tw_en, tw_bypass, frame_done})
  );

  assign tw_addr = tw_addr_q;
  assign busy    = (state_q == RUN);

endmodule

`default_nettype wire
